// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared width default and FSM state type for the sqrt reconstruction block
package sqrt_pkg;
   localparam int DW_DEF = 16;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/sqrt_iter_cnt.sv
// sqrt_iter_cnt: iteration counter; ports clk, reset (async high), load (set to DW), dec (count down), count, zero
module sqrt_iter_cnt
   import sqrt_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          dec,
   output logic [DW-1:0] count,
   output logic          zero
);
   assign zero = count == '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (load) count <= DW'(DW);
      else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/sqrt_recon.sv
// sqrt_recon: rebuilds radicand D = root*root + remainder by shift-add; ports clk, reset, start, root, remainder, expected -> D, count, busy, ready, mismatch; optional MISMATCH_CHECK_EN compares D with expected
module sqrt_recon
   import sqrt_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [DW-1:0]   root,
   input  logic [DW-1:0]   remainder,
   input  logic [2*DW-1:0] expected,
   output logic [2*DW-1:0] D,
   output logic [DW-1:0]   count,
   output logic            busy,
   output logic            ready,
   output logic            mismatch
);
   state_t          state;
   logic [DW-1:0]   root_reg;
   logic [2*DW-1:0] acc;
   logic            zero;
   logic            accept;
   logic [DW-1:0]   idx;
   logic [DW-1:0]   root_sh;
   logic [2*DW-1:0] addend;
   assign accept  = start && state != BUSY;
   assign busy    = state == BUSY;
   // bit position handled this cycle; only meaningful while count is nonzero
   assign idx     = DW'(DW) - count;
   assign root_sh = root_reg >> idx;
   assign addend  = {{DW{1'b0}}, root_reg} << idx;
   sqrt_iter_cnt #(.DW(DW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .dec   (busy),
      .count (count),
      .zero  (zero)
   );
`ifdef MISMATCH_CHECK_EN
   logic [2*DW-1:0] exp_reg;
   always_ff @(posedge clk or posedge reset)
      if (reset) exp_reg <= '0;
      else if (accept) exp_reg <= expected;
`else
   logic unused_expected;
   assign unused_expected = ^expected;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         root_reg <= '0;
         acc      <= '0;
         D        <= '0;
         ready    <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         ready    <= 1'b0;
         mismatch <= 1'b0;
         if (accept) begin
            state    <= BUSY;
            root_reg <= root;
            acc      <= {{DW{1'b0}}, remainder};
         end else if (state == BUSY) begin
            if (zero) begin
               state <= DONE;
               D     <= acc;
               ready <= 1'b1;
`ifdef MISMATCH_CHECK_EN
               mismatch <= acc != exp_reg;
`endif
            end else if (root_sh[0]) begin
               acc <= acc + addend;
            end
         end else if (state == DONE) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_sqrt_recon.sv
// tb_sqrt_recon: table-driven and directed checks of sqrt_recon with a result scoreboard
module tb_sqrt_recon;
   localparam int DW = 16;
   typedef struct {
      logic [DW-1:0]   r;
      logic [DW-1:0]   rm;
      logic [2*DW-1:0] e;
      logic [2*DW-1:0] d;
   } vec_t;
   typedef struct {
      logic [2*DW-1:0] d;
      logic            m;
   } res_t;
   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [DW-1:0]   root = '0;
   logic [DW-1:0]   remainder = '0;
   logic [2*DW-1:0] expected = '0;
   logic [2*DW-1:0] D;
   logic [DW-1:0]   count;
   logic            busy;
   logic            ready;
   logic            mismatch;
   int              checks = 0;
   int              errors = 0;
   res_t            q[$];
   vec_t            tbl[10];
   always #5 clk = ~clk;
   sqrt_recon #(.DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .root      (root),
      .remainder (remainder),
      .expected  (expected),
      .D         (D),
      .count     (count),
      .busy      (busy),
      .ready     (ready),
      .mismatch  (mismatch)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   function automatic logic mis(input logic [2*DW-1:0] d, input logic [2*DW-1:0] e);
`ifdef MISMATCH_CHECK_EN
      return d != e;
`else
      return 1'b0;
`endif
   endfunction
   always @(negedge clk) begin
      if (!reset) begin
         if (ready) begin
            if (q.size() == 0) begin
               chk("unexpected ready", 1, 0);
            end else begin
               res_t x;
               x = q.pop_front();
               chk("D", D, x.d);
               chk("mismatch with ready", mismatch, x.m);
            end
         end else begin
            chk("mismatch without ready", mismatch, 0);
         end
      end
   end
   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!ready && n < 50);
      chk("ready seen", ready, 1);
   endtask
   task automatic run_op(input vec_t v);
      @(negedge clk);
      start = 1'b1;
      root = v.r;
      remainder = v.rm;
      expected = v.e;
      q.push_back('{d: v.d, m: mis(v.d, v.e)});
      @(posedge clk);
      #1 start = 1'b0;
      root = DW'($urandom);
      remainder = DW'($urandom);
      expected = $urandom;
      chk("count after load", count, DW);
      chk("busy after load", busy, 1);
      for (int n = 1; n <= DW + 1; n++) begin
         @(posedge clk);
         #1;
         if (n <= DW) begin
            chk("count step", count, DW - n);
            chk("no early ready", ready, 0);
         end else begin
            chk("ready at latency", ready, 1);
            chk("busy cleared", busy, 0);
         end
      end
      @(posedge clk);
      #1 chk("ready single pulse", ready, 0);
      chk("D held", D, v.d);
   endtask
   initial begin
      int n;
      logic [DW-1:0] r, rm;
      tbl[0] = '{r: 16'd11, rm: 16'd6, e: 32'd128, d: 32'd127};
      tbl[1] = '{r: 16'd11, rm: 16'd6, e: 32'd127, d: 32'd127};
      tbl[2] = '{r: 16'd0, rm: 16'd0, e: 32'd0, d: 32'd0};
      tbl[3] = '{r: 16'hFFFF, rm: 16'hFFFF, e: 32'd0, d: 32'hFFFF0000};
      tbl[4] = '{r: 16'd1, rm: 16'd0, e: 32'd1, d: 32'd1};
      tbl[5] = '{r: 16'd255, rm: 16'd3, e: 32'd65028, d: 32'd65028};
      tbl[6] = '{r: 16'd1234, rm: 16'd5, e: 32'd7, d: 32'd1522761};
      for (int i = 7; i < 10; i++) begin
         r = DW'($urandom);
         rm = DW'($urandom);
         tbl[i] = '{r: r, rm: rm, e: $urandom, d: {16'd0, r} * {16'd0, r} + {16'd0, rm}};
      end
      #1;
      chk("reset D", D, 0);
      chk("reset count", count, 0);
      chk("reset busy", busy, 0);
      chk("reset ready", ready, 0);
      chk("reset mismatch", mismatch, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) run_op(tbl[i]);
      @(negedge clk);
      start = 1'b1;
      root = 16'd11;
      remainder = 16'd6;
      expected = 32'd127;
      q.push_back('{d: 32'd127, m: mis(32'd127, 32'd127)});
      @(posedge clk);
      @(negedge clk);
      root = 16'd200;
      wait_ready(n);
      chk("held start latency", n, DW + 1);
      q.push_back('{d: 32'd40006, m: mis(32'd40006, 32'd127)});
      @(posedge clk);
      #1 start = 1'b0;
      chk("back-to-back accept busy", busy, 1);
      chk("back-to-back accept count", count, DW);
      wait_ready(n);
      chk("back-to-back latency", n, DW + 1);
      @(negedge clk);
      start = 1'b1;
      root = 16'd11;
      remainder = 16'd6;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (count != 5 && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk("reached count 5", count, 5);
      #2 reset = 1'b1;
      #1;
      chk("abort D", D, 0);
      chk("abort count", count, 0);
      chk("abort busy", busy, 0);
      chk("abort ready", ready, 0);
      chk("abort mismatch", mismatch, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(posedge clk);
      #1 chk("idle after abort", busy, 0);
      run_op(tbl[0]);
      repeat (3) @(posedge clk);
      #1 chk("scoreboard drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
